// File: rtl/t03_combat_arbiter_if.sv
// Signal bundle between the frame/player logic and the combat arbiter.
// The master side drives the frame tick, start and player actions; the slave side returns health, hits and match status.
interface t03_combat_arbiter_if;
    logic       finished;
    logic       start;
    logic [1:0] p1_state;
    logic       p1_resting;
    logic [1:0] p2_state;
    logic       p2_resting;
    logic [7:0] p1_health;
    logic [7:0] p2_health;
    logic       p1_hit;
    logic       p2_hit;
    logic [1:0] game_state;
    logic [1:0] winner;

    modport master (
        output finished, start, p1_state, p1_resting, p2_state, p2_resting,
        input  p1_health, p2_health, p1_hit, p2_hit, game_state, winner
    );

    modport slave (
        input  finished, start, p1_state, p1_resting, p2_state, p2_resting,
        output p1_health, p2_health, p1_hit, p2_hit, game_state, winner
    );
endinterface

// File: rtl/t03_combat_arbiter.sv
// Combat referee: detects strike edges, resolves damage against guard and post-hit immunity,
// tracks both health bars and runs the IDLE/FIGHT/KO/OVER match sequence on frame ticks.
module t03_combat_arbiter #(
    parameter logic [7:0] MAX_HEALTH   = 8'd100,
    parameter logic [7:0] PUNCH_DAMAGE = 8'd10,
    parameter logic [7:0] CHIP_DAMAGE  = 8'd2,
    parameter logic [3:0] HIT_COOLDOWN = 4'd8,
    parameter logic [7:0] KO_HOLD      = 8'd120
) (
    input logic                  clk,
    input logic                  nrst,
    t03_combat_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIGHT = 2'b01,
        ST_KO    = 2'b10,
        ST_OVER  = 2'b11
    } game_state_t;

    localparam logic [1:0] ACT_PUNCH = 2'b01;
    localparam logic [1:0] ACT_BLOCK = 2'b10;

    function automatic logic [7:0] sat_sub(input logic [7:0] value, input logic [7:0] amount);
        logic [7:0] result;
        if (value > amount) begin
            result = value - amount;
        end else begin
            result = 8'd0;
        end
        return result;
    endfunction

    function automatic logic [3:0] cool_step(input logic [3:0] count, input logic load);
        logic [3:0] result;
        if (load) begin
            result = HIT_COOLDOWN;
        end else if (count != 4'd0) begin
            result = count - 4'd1;
        end else begin
            result = 4'd0;
        end
        return result;
    endfunction

    game_state_t state_r;
    logic [7:0]  p1_health_r;
    logic [7:0]  p2_health_r;
    logic        p1_hit_r;
    logic        p2_hit_r;
    logic [1:0]  winner_r;
    logic [3:0]  p1_cool_r;
    logic [3:0]  p2_cool_r;
    logic [7:0]  ko_cnt_r;
    logic        p1_prev_r;
    logic        p2_prev_r;

    logic        p1_active_s;
    logic        p2_active_s;
    logic        p1_strike_s;
    logic        p2_strike_s;
    logic        p1_guard_s;
    logic        p2_guard_s;
    logic        p1_land_s;
    logic        p2_land_s;
    logic [7:0]  p1_dmg_s;
    logic [7:0]  p2_dmg_s;
    logic [7:0]  p1_health_next_s;
    logic [7:0]  p2_health_next_s;
    logic [3:0]  p1_cool_next_s;
    logic [3:0]  p2_cool_next_s;
    logic        p1_zero_s;
    logic        p2_zero_s;
    logic        ko_now_s;

    // Strike edges, guard and damage resolution for this frame; p1_land_s means p1 is the one taking damage.
    always_comb begin
        p1_active_s = (bus.p1_state == ACT_PUNCH) && !bus.p1_resting;
        p2_active_s = (bus.p2_state == ACT_PUNCH) && !bus.p2_resting;
        p1_strike_s = p1_active_s && !p1_prev_r;
        p2_strike_s = p2_active_s && !p2_prev_r;
        p1_guard_s  = (bus.p1_state == ACT_BLOCK) && !bus.p1_resting;
        p2_guard_s  = (bus.p2_state == ACT_BLOCK) && !bus.p2_resting;

        p1_land_s = (state_r == ST_FIGHT) && p2_strike_s && (p1_cool_r == 4'd0);
        p2_land_s = (state_r == ST_FIGHT) && p1_strike_s && (p2_cool_r == 4'd0);

        if (p1_guard_s) begin
            p1_dmg_s = CHIP_DAMAGE;
        end else begin
            p1_dmg_s = PUNCH_DAMAGE;
        end
        if (p2_guard_s) begin
            p2_dmg_s = CHIP_DAMAGE;
        end else begin
            p2_dmg_s = PUNCH_DAMAGE;
        end

        if (p1_land_s) begin
            p1_health_next_s = sat_sub(p1_health_r, p1_dmg_s);
        end else begin
            p1_health_next_s = p1_health_r;
        end
        if (p2_land_s) begin
            p2_health_next_s = sat_sub(p2_health_r, p2_dmg_s);
        end else begin
            p2_health_next_s = p2_health_r;
        end

        p1_cool_next_s = cool_step(p1_cool_r, p1_land_s);
        p2_cool_next_s = cool_step(p2_cool_r, p2_land_s);

        p1_zero_s = (p1_health_next_s == 8'd0);
        p2_zero_s = (p2_health_next_s == 8'd0);
        ko_now_s  = p1_zero_s || p2_zero_s;
    end

    // Match sequencer and all registered outputs; everything except the hit pulses waits for a frame tick.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            p1_health_r <= MAX_HEALTH;
            p2_health_r <= MAX_HEALTH;
            p1_hit_r    <= 1'b0;
            p2_hit_r    <= 1'b0;
            winner_r    <= 2'b00;
            p1_cool_r   <= 4'd0;
            p2_cool_r   <= 4'd0;
            ko_cnt_r    <= 8'd0;
            p1_prev_r   <= 1'b0;
            p2_prev_r   <= 1'b0;
        end else begin
            p1_hit_r <= 1'b0;
            p2_hit_r <= 1'b0;
            if (bus.finished) begin
                p1_prev_r <= p1_active_s;
                p2_prev_r <= p2_active_s;
                p1_cool_r <= p1_cool_next_s;
                p2_cool_r <= p2_cool_next_s;
                case (state_r)
                    ST_IDLE, ST_OVER: begin
                        if (bus.start) begin
                            state_r     <= ST_FIGHT;
                            p1_health_r <= MAX_HEALTH;
                            p2_health_r <= MAX_HEALTH;
                            p1_cool_r   <= 4'd0;
                            p2_cool_r   <= 4'd0;
                            winner_r    <= 2'b00;
                            ko_cnt_r    <= 8'd0;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_FIGHT: begin
                        p1_health_r <= p1_health_next_s;
                        p2_health_r <= p2_health_next_s;
                        p1_hit_r    <= p1_land_s;
                        p2_hit_r    <= p2_land_s;
                        if (ko_now_s) begin
                            state_r  <= ST_KO;
                            ko_cnt_r <= 8'd0;
                            winner_r <= {p1_zero_s, p2_zero_s};
                        end else begin
                            state_r <= ST_FIGHT;
                        end
                    end
                    ST_KO: begin
                        if (ko_cnt_r == (KO_HOLD - 8'd1)) begin
                            state_r <= ST_OVER;
                        end else begin
                            ko_cnt_r <= ko_cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.p1_health  = p1_health_r;
    assign bus.p2_health  = p2_health_r;
    assign bus.p1_hit     = p1_hit_r;
    assign bus.p2_hit     = p2_hit_r;
    assign bus.game_state = state_r;
    assign bus.winner     = winner_r;

endmodule

// File: tb/tb_t03_combat_arbiter.sv
// Bench for t03_combat_arbiter: directed match fragments followed by random play,
// all outputs compared each cycle against a frame-level model of the match rules.
module tb_t03_combat_arbiter;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    t03_combat_arbiter_if bus();

    t03_combat_arbiter dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference match state: 0 idle, 1 fight, 2 ko, 3 over
    int m_phase;
    int m_h1;
    int m_h2;
    int m_cd1;
    int m_cd2;
    int m_ko;
    int m_win;
    bit m_prev1;
    bit m_prev2;
    bit m_hit1;
    bit m_hit2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_h1 = 100;
        m_h2 = 100;
        m_cd1 = 0;
        m_cd2 = 0;
        m_ko = 0;
        m_win = 0;
        m_prev1 = 1'b0;
        m_prev2 = 1'b0;
        m_hit1 = 1'b0;
        m_hit2 = 1'b0;
    endtask

    task automatic model_step(input bit fin, input bit st, input int s1, input int r1,
                              input int s2, input int r2);
        bit a1, a2, new1, new2, g1, g2;
        int old_cd1, old_cd2;
        m_hit1 = 1'b0;
        m_hit2 = 1'b0;
        if (fin) begin
            a1 = (s1 == 1) && (r1 == 0);
            a2 = (s2 == 1) && (r2 == 0);
            g1 = (s1 == 2) && (r1 == 0);
            g2 = (s2 == 2) && (r2 == 0);
            new1 = a1 && !m_prev1;
            new2 = a2 && !m_prev2;
            m_prev1 = a1;
            m_prev2 = a2;
            old_cd1 = m_cd1;
            old_cd2 = m_cd2;
            if (m_cd1 > 0) m_cd1 = m_cd1 - 1;
            if (m_cd2 > 0) m_cd2 = m_cd2 - 1;
            if (m_phase == 0 || m_phase == 3) begin
                if (st) begin
                    m_phase = 1;
                    m_h1 = 100;
                    m_h2 = 100;
                    m_cd1 = 0;
                    m_cd2 = 0;
                    m_win = 0;
                end
            end else if (m_phase == 1) begin
                if (new1 && old_cd2 == 0) begin
                    m_h2 = m_h2 - (g2 ? 2 : 10);
                    if (m_h2 < 0) m_h2 = 0;
                    m_hit2 = 1'b1;
                    m_cd2 = 8;
                end
                if (new2 && old_cd1 == 0) begin
                    m_h1 = m_h1 - (g1 ? 2 : 10);
                    if (m_h1 < 0) m_h1 = 0;
                    m_hit1 = 1'b1;
                    m_cd1 = 8;
                end
                if (m_h1 == 0 || m_h2 == 0) begin
                    m_win = (m_h1 == 0 ? 2 : 0) + (m_h2 == 0 ? 1 : 0);
                    m_phase = 2;
                    m_ko = 0;
                end
            end else begin
                m_ko = m_ko + 1;
                if (m_ko == 120) m_phase = 3;
            end
        end
    endtask

    task automatic compare_all();
        check_val("game_state", bus.game_state, m_phase);
        check_val("p1_health", bus.p1_health, m_h1);
        check_val("p2_health", bus.p2_health, m_h2);
        check_val("p1_hit", bus.p1_hit, m_hit1);
        check_val("p2_hit", bus.p2_hit, m_hit2);
        check_val("winner", bus.winner, m_win);
    endtask

    task automatic drive(input bit fin, input bit st, input int s1, input int r1,
                         input int s2, input int r2);
        @(negedge clk);
        bus.finished   = fin;
        bus.start      = st;
        bus.p1_state   = 2'(s1);
        bus.p1_resting = r1[0];
        bus.p2_state   = 2'(s2);
        bus.p2_resting = r2[0];
        model_step(fin, st, s1, r1, s2, r2);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int guard_cnt;
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        bus.finished = 1'b0;
        bus.start = 1'b0;
        bus.p1_state = 2'b00;
        bus.p1_resting = 1'b1;
        bus.p2_state = 2'b00;
        bus.p2_resting = 1'b1;
        model_reset();
        #12;
        check_val("rst_state", bus.game_state, 0);
        check_val("rst_p1_health", bus.p1_health, 100);
        check_val("rst_p2_health", bus.p2_health, 100);
        check_val("rst_winner", bus.winner, 0);
        check_val("rst_hits", {bus.p1_hit, bus.p2_hit}, 0);
        @(negedge clk);
        nrst = 1'b1;

        drive(1'b1, 1'b1, 0, 1, 0, 1);
        check_val("start_fight", bus.game_state, 1);
        drive(1'b1, 1'b0, 1, 0, 0, 1);
        check_val("first_punch_p2", bus.p2_health, 90);
        check_val("first_punch_hit", bus.p2_hit, 1);
        check_val("first_punch_p1", bus.p1_health, 100);
        drive(1'b0, 1'b0, 1, 0, 0, 1);
        check_val("hit_one_cycle", bus.p2_hit, 0);
        drive(1'b1, 1'b0, 1, 1, 0, 1);
        drive(1'b1, 1'b0, 1, 1, 0, 1);
        drive(1'b1, 1'b0, 1, 0, 0, 1);
        check_val("cooldown_ignore", bus.p2_health, 90);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1, 0, 0, 1);
        check_val("hold_single_hit", bus.p2_health, 90);
        drive(1'b1, 1'b0, 1, 1, 2, 0);
        drive(1'b1, 1'b0, 1, 0, 2, 0);
        check_val("chip_damage", bus.p2_health, 88);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 0, 1, 0, 1);
        drive(1'b1, 1'b0, 1, 0, 1, 0);
        check_val("dual_p1_health", bus.p1_health, 90);
        check_val("dual_p2_health", bus.p2_health, 78);
        check_val("dual_hits", {bus.p1_hit, bus.p2_hit}, 2'b11);

        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 1 : 0,
                  $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        guard_cnt = 0;
        while (m_phase != 1 && guard_cnt < 300) begin
            drive(1'b1, 1'b1, 0, 1, 0, 1);
            guard_cnt++;
        end
        check_val("reach_fight", m_phase, 1);
        drive(1'b1, 1'b0, 1, 0, 0, 1);
        @(negedge clk);
        bus.finished = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_state", bus.game_state, 0);
        check_val("async_rst_p1", bus.p1_health, 100);
        check_val("async_rst_p2", bus.p2_health, 100);
        check_val("async_rst_winner", bus.winner, 0);
        @(negedge clk);
        nrst = 1'b1;
        drive(1'b1, 1'b0, 1, 0, 1, 0);
        drive(1'b1, 1'b1, 1, 0, 1, 0);
        drive(1'b1, 1'b0, 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
